uart_wb_arbiter: RTL and testbench

Two-master Wishbone arbiter that shares the single uart Wishbone slave port. Master 0 is the management SoC path. Master 1 is a user-side requester (DMA/test engine). The block sits between the wrapper's wbs_* bus plus the second master and the uart instance's wbs_* inputs. It provides round-robin grant, cycle-hold (grant kept while CYC is high), and an optional stuck-slave timeout.

---
 rtl/uart_wb_arbiter.sv | 104 ++++++++++
 tb/tb_uart_wb_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_wb_arbiter.sv
// uart_wb_arbiter: two-master round-robin Wishbone arbiter in front of the uart slave port.
// Ports: wb_clk_i/wb_rst_i clock and sync active-high reset; m0_*/m1_* master buses;
// s_* shared slave bus to the uart; grant_o one-hot owner (00 idle); timeout_o forced-termination pulse.
// Optional stuck-slave timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_wb_arbiter #(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic        m0_ack_o,
    output logic [31:0] m0_dat_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic        m1_ack_o,
    output logic [31:0] m1_dat_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,
    output logic [1:0]  grant_o,
    output logic        timeout_o
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t      state, state_n;
    logic        owner, owner_n, last_owner, last_n;
    logic        req0, req1, live, ack_int;
    logic [31:0] dat_int;
    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_owner <= last_n;
        end
    end
    // owner encoding: 0 = m0, 1 = m1; a tie goes to whoever did not own the bus last
    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n  = last_owner;
        if (state == IDLE) begin
            if (req0 | req1) begin
                state_n = BUSY;
                owner_n = (req0 & req1) ? ~last_owner : req1;
            end
        end else if (!(owner ? m1_cyc_i : m0_cyc_i)) begin
            state_n = IDLE;
            last_n  = owner;
        end
    end
`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] cnt;
    logic        fire, fire_d;
    assign fire_d = (state == BUSY) && s_stb_o && !s_ack_i && (cnt == 16'(TIMEOUT - 1));
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt  <= 16'd0;
            fire <= 1'b0;
        end else begin
            fire <= fire_d;
            cnt  <= (state == IDLE || s_ack_i || fire_d) ? 16'd0 : cnt + {15'd0, s_stb_o};
        end
    end
    // the owner may drop CYC at the same edge the timeout fires; only pulse while still owned
    assign timeout_o = fire & (state == BUSY);
`else
    assign timeout_o = 1'b0;
`endif
    // during a forced termination the slave is disconnected and the master gets ERR_DATA
    assign live     = (state == BUSY) & ~timeout_o;
    assign s_cyc_o  = live & (owner ? m1_cyc_i : m0_cyc_i);
    assign s_stb_o  = live & (owner ? m1_stb_i : m0_stb_i);
    assign s_we_o   = live & (owner ? m1_we_i : m0_we_i);
    assign s_sel_o  = live ? (owner ? m1_sel_i : m0_sel_i) : 4'd0;
    assign s_adr_o  = live ? (owner ? m1_adr_i : m0_adr_i) : 32'd0;
    assign s_dat_o  = live ? (owner ? m1_dat_i : m0_dat_i) : 32'd0;
    assign ack_int  = timeout_o | (live & s_ack_i);
    assign dat_int  = timeout_o ? ERR_DATA : (live ? s_dat_i : 32'd0);
    assign m0_ack_o = ack_int & ~owner;
    assign m1_ack_o = ack_int & owner;
    assign m0_dat_o = owner ? 32'd0 : dat_int;
    assign m1_dat_o = owner ? dat_int : 32'd0;
    assign grant_o  = (state == BUSY) ? (owner ? 2'b10 : 2'b01) : 2'b00;
endmodule

// File: tb/tb_uart_wb_arbiter.sv
// tb_uart_wb_arbiter: scoreboard bench for uart_wb_arbiter (timeout scenario when UART_ARB_TIMEOUT_EN is defined).
module tb_uart_wb_arbiter;
    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]  m0_sel_i, m1_sel_i, s_sel_o;
    logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
    logic        m0_ack_o, m1_ack_o, s_cyc_o, s_stb_o, s_we_o, s_ack_i, timeout_o;
    logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o, s_dat_i;
    logic [1:0]  grant_o;
    logic [139:0] all_out;
    int checks = 0;
    int failures = 0;
    logic [33:0] ack_q[$];
    logic [31:0] wr_q[$];

    uart_wb_arbiter #(.TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    assign all_out = {grant_o, timeout_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
                      m0_ack_o, m1_ack_o, m0_dat_o, m1_dat_o};

    always #5 wb_clk_i = ~wb_clk_i;

    // one clock cycle: scoreboard pops at the falling edge, inputs change #1 after the rising edge
    task automatic step();
        logic [33:0] e;
        logic [33:0] got;
        @(negedge wb_clk_i);
        if (m0_ack_o || m1_ack_o) begin
            checks++;
            got = {m1_ack_o, m0_ack_o, m1_ack_o ? m1_dat_o : m0_dat_o};
            if (ack_q.size() == 0) begin
                failures++;
                $display("FAIL ack_unexpected got ack=%b dat=%h want no ack", got[33:32], got[31:0]);
            end else begin
                e = ack_q.pop_front();
                if (got !== e) begin
                    failures++;
                    $display("FAIL ack_data got ack=%b dat=%h want ack=%b dat=%h", got[33:32], got[31:0], e[33:32], e[31:0]);
                end
            end
        end
        if (s_stb_o && s_ack_i && s_we_o) begin
            checks++;
            if (wr_q.size() == 0) begin
                failures++;
                $display("FAIL write_unexpected got s_dat_o=%h want no write", s_dat_o);
            end else if (s_dat_o !== wr_q[0]) begin
                failures++;
                $display("FAIL write_data got s_dat_o=%h want %h", s_dat_o, wr_q[0]);
                void'(wr_q.pop_front());
            end else begin
                void'(wr_q.pop_front());
            end
        end
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic drive(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat);
        if (m == 0) begin
            m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_sel_i = 4'hf; m0_adr_i = adr; m0_dat_i = dat;
        end else begin
            m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_sel_i = 4'hf; m1_adr_i = adr; m1_dat_i = dat;
        end
    endtask

    task automatic apply_reset();
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        s_ack_i = 0; s_dat_i = 0;
        wb_rst_i = 1;
        step();
        wb_rst_i = 0;
    endtask

    task automatic check_grant(input string name, input logic [1:0] want);
        checks++;
        if (grant_o !== want) begin
            failures++;
            $display("FAIL %s got grant=%b want %b", name, grant_o, want);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (ack_q.size() != 0 || wr_q.size() != 0) begin
            failures++;
            $display("FAIL %s got pending acks=%0d writes=%0d want 0", name, ack_q.size(), wr_q.size());
        end
        ack_q.delete();
        wr_q.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (all_out !== '0) begin
            failures++;
            $display("FAIL reset_outputs got %h want 0", all_out);
        end
    endtask

    task automatic test_single_read();
        apply_reset();
        drive(0, 1, 1, 0, 32'h3000_0000, 0);
        check_grant("read_idle", 2'b00);
        step();
        checks++;
        if ({grant_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o} !== {2'b01, 3'b110, 32'h3000_0000}) begin
            failures++;
            $display("FAIL read_busy got grant=%b cyc=%b stb=%b we=%b adr=%h want 01 1 1 0 30000000",
                     grant_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o);
        end
        step();
        step();
        s_ack_i = 1; s_dat_i = 32'h0000_0041;
        ack_q.push_back({2'b01, 32'h0000_0041});
        step();
        s_ack_i = 0; s_dat_i = 0;
        drive(0, 0, 0, 0, 0, 0);
        step();
        check_grant("read_release", 2'b00);
        check_drained("read_drain");
    endtask

    task automatic test_tie();
        apply_reset();
        drive(0, 1, 1, 0, 32'h100, 0);
        drive(1, 1, 1, 0, 32'h200, 0);
        step();
        check_grant("tie_first", 2'b01);
        s_ack_i = 1; s_dat_i = 32'hA0;
        ack_q.push_back({2'b01, 32'hA0});
        step();
        s_ack_i = 0;
        drive(0, 0, 0, 0, 0, 0);
        step();
        check_grant("tie_gap", 2'b00);
        step();
        check_grant("tie_second", 2'b10);
        s_ack_i = 1; s_dat_i = 32'hB1;
        ack_q.push_back({2'b10, 32'hB1});
        step();
        s_ack_i = 0;
        drive(0, 1, 1, 0, 32'h100, 0);
        drive(1, 0, 0, 0, 0, 0);
        step();
        check_grant("tie_gap2", 2'b00);
        drive(1, 1, 1, 0, 32'h200, 0);
        step();
        check_grant("tie_alternate", 2'b01);
        s_ack_i = 1; s_dat_i = 32'hC2;
        ack_q.push_back({2'b01, 32'hC2});
        step();
        s_ack_i = 0;
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        step();
        step();
        check_grant("tie_idle", 2'b00);
        check_drained("tie_drain");
    endtask

    task automatic test_back_to_back();
        apply_reset();
        drive(1, 1, 1, 1, 32'h10, 1);
        step();
        check_grant("b2b_grant", 2'b10);
        drive(0, 1, 1, 0, 32'h300, 0);
        for (int i = 1; i <= 4; i++) begin
            m1_dat_i = i;
            s_ack_i = 1; s_dat_i = 0;
            wr_q.push_back(i);
            ack_q.push_back({2'b10, 32'h0});
            step();
            check_grant("b2b_hold", 2'b10);
        end
        s_ack_i = 0;
        drive(1, 0, 0, 0, 0, 0);
        step();
        check_grant("b2b_release", 2'b00);
        step();
        check_grant("b2b_m0", 2'b01);
        drive(0, 0, 0, 0, 0, 0);
        step();
        step();
        check_drained("b2b_drain");
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive(1, 1, 1, 0, 32'h20, 0);
        step();
        check_grant("rst_mid_grant", 2'b10);
        step();
        wb_rst_i = 1;
        step();
        checks++;
        if (all_out !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs got %h want 0", all_out);
        end
        wb_rst_i = 0;
        s_ack_i = 1; s_dat_i = 32'h77;
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 32'h30, 0);
        step();
        check_grant("rst_mid_m0", 2'b01);
        s_ack_i = 1; s_dat_i = 32'h66;
        ack_q.push_back({2'b01, 32'h66});
        step();
        s_ack_i = 0; s_dat_i = 0;
        drive(0, 0, 0, 0, 0, 0);
        step();
        step();
        check_drained("rst_mid_drain");
    endtask

    task automatic test_drop_grant();
        apply_reset();
        drive(0, 1, 1, 0, 32'h40, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if ({grant_o, s_cyc_o, s_stb_o} !== 4'b0100) begin
            failures++;
            $display("FAIL drop_grant got grant=%b cyc=%b stb=%b want 01 0 0", grant_o, s_cyc_o, s_stb_o);
        end
        step();
        check_grant("drop_idle", 2'b00);
        drive(0, 1, 1, 0, 32'h50, 0);
        drive(1, 1, 1, 0, 32'h60, 0);
        step();
        check_grant("drop_last_owner", 2'b10);
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        step();
        step();
        check_drained("drop_drain");
    endtask

`ifdef UART_ARB_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        drive(0, 1, 1, 0, 32'h3000_0004, 0);
        step();
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if ({timeout_o, s_stb_o} !== 2'b01) begin
                failures++;
                $display("FAIL timeout_wait cycle=%0d got to=%b stb=%b want 0 1", k, timeout_o, s_stb_o);
            end
            step();
        end
        checks++;
        if ({timeout_o, s_cyc_o, s_stb_o, m0_ack_o, m0_dat_o} !== {4'b1001, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL timeout_fire got to=%b cyc=%b stb=%b ack=%b dat=%h want 1 0 0 1 deadbeef",
                     timeout_o, s_cyc_o, s_stb_o, m0_ack_o, m0_dat_o);
        end
        ack_q.push_back({2'b01, 32'hDEAD_BEEF});
        s_ack_i = 1; s_dat_i = 32'h55;
        step();
        s_ack_i = 0; s_dat_i = 0;
        checks++;
        if (timeout_o !== 1'b0) begin
            failures++;
            $display("FAIL timeout_once got to=%b want 0", timeout_o);
        end
        drive(0, 0, 0, 0, 0, 0);
        step();
        step();
        check_drained("timeout_drain");
    endtask
`endif

    initial begin
        wb_rst_i = 1;
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        s_ack_i = 0; s_dat_i = 0;
        @(posedge wb_clk_i);
        #1;
        test_reset();
        test_single_read();
        test_tie();
        test_back_to_back();
        test_reset_mid();
        test_drop_grant();
`ifdef UART_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
